monitor_spi_master: RTL and testbench

//  SPI master that polls the board monitor slave: generates SPICLK/SPISS, shifts out a 4-bit input-signal command and shifts in the 56-bit monitor frame.

---
 rtl/monitor_spi_master_if.sv | 29 ++
 rtl/monitor_spi_master.sv | 204 ++++++++++++++++++++
 tb/tb_monitor_spi_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_spi_master_if.sv
// Bus bundle between the monitor SPI master and its host/slave side: poll request,
// SPI pins and the decoded monitor frame.
interface monitor_spi_master_if;
  logic        START_IN;
  logic [3:0]  INPUT_SIGNAL_IN;
  logic        SPISO_IN;
  logic        SPICLK;
  logic        SPISI;
  logic        SPISS;
  logic        BUSY;
  logic        FRAME_VALID;
  logic [23:0] ADDR;
  logic [15:0] DATA;
  logic [3:0]  OUTPUT_SIGNAL;
  logic        UART_VALID;
  logic [7:0]  UART_BYTE;

  modport master (
    input  START_IN, INPUT_SIGNAL_IN, SPISO_IN,
    output SPICLK, SPISI, SPISS, BUSY, FRAME_VALID,
           ADDR, DATA, OUTPUT_SIGNAL, UART_VALID, UART_BYTE
  );

  modport slave (
    output START_IN, INPUT_SIGNAL_IN, SPISO_IN,
    input  SPICLK, SPISI, SPISS, BUSY, FRAME_VALID,
           ADDR, DATA, OUTPUT_SIGNAL, UART_VALID, UART_BYTE
  );
endinterface

// File: rtl/monitor_spi_master.sv
// SPI MODE1 master polling the board monitor: sends a 4-bit command, receives a 56-bit frame.
// Define AUTO_POLL_EN to restart polling automatically after each SS_GAP.
module monitor_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_GAP   = 8
) (
  input  logic                 MCLK_IN,
  input  logic                 RESET_IN,
  monitor_spi_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_DONE   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
  localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);
  localparam logic [5:0]  EDGE_LAST  = 6'd55;

  state_t      state_r, state_next_s;
  logic [15:0] timer_r, timer_next_s;
  logic [5:0]  edge_r, edge_next_s, edge_inc_s;
  logic [7:0]  cmd_r, cmd_next_s;
  logic [55:0] shift_r, shift_next_s;
  logic        spiclk_r, spiclk_next_s;
  logic        spisi_r, spisi_next_s;
  logic        spiss_r, spiss_next_s;
  logic        busy_r, busy_next_s;
  logic        fv_r, fv_next_s;
  logic [23:0] addr_r, addr_next_s;
  logic [15:0] data_r, data_next_s;
  logic [3:0]  osig_r, osig_next_s;
  logic        uvalid_r, uvalid_next_s;
  logic [7:0]  ubyte_r, ubyte_next_s;

  assign edge_inc_s = edge_r + 6'd1;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next_s  = state_r;
    timer_next_s  = timer_r;
    edge_next_s   = edge_r;
    cmd_next_s    = cmd_r;
    shift_next_s  = shift_r;
    spiclk_next_s = spiclk_r;
    spisi_next_s  = spisi_r;
    spiss_next_s  = spiss_r;
    busy_next_s   = busy_r;
    fv_next_s     = 1'b0;
    addr_next_s   = addr_r;
    data_next_s   = data_r;
    osig_next_s   = osig_r;
    uvalid_next_s = uvalid_r;
    ubyte_next_s  = ubyte_r;

    case (state_r)
      ST_IDLE: begin
        timer_next_s = 16'd0;
        edge_next_s  = 6'd0;
        if (bus.START_IN) begin
          cmd_next_s   = {4'b0000, bus.INPUT_SIGNAL_IN};
          spiss_next_s = 1'b1;
          busy_next_s  = 1'b1;
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (timer_r == SETUP_LAST) begin
          timer_next_s  = 16'd0;
          spiclk_next_s = 1'b1;
          spisi_next_s  = cmd_r[0];
          state_next_s  = ST_CLK_HI;
        end else begin
          timer_next_s = timer_r + 16'd1;
        end
      end
      ST_CLK_HI: begin
        if (timer_r == DIV_LAST) begin
          timer_next_s  = 16'd0;
          spiclk_next_s = 1'b0;
          shift_next_s  = {bus.SPISO_IN, shift_r[55:1]};
          state_next_s  = ST_CLK_LO;
        end else begin
          timer_next_s = timer_r + 16'd1;
        end
      end
      ST_CLK_LO: begin
        if (timer_r == DIV_LAST) begin
          timer_next_s = 16'd0;
          if (edge_r == EDGE_LAST) begin
            edge_next_s  = 6'd0;
            spiss_next_s = 1'b0;
            spisi_next_s = 1'b0;
            state_next_s = ST_DONE;
          end else begin
            edge_next_s   = edge_inc_s;
            spiclk_next_s = 1'b1;
            // Only the low command byte is meaningful; later bits are sent as zero.
            if (edge_r < 6'd7) begin
              spisi_next_s = cmd_r[edge_inc_s[2:0]];
            end else begin
              spisi_next_s = 1'b0;
            end
            state_next_s = ST_CLK_HI;
          end
        end else begin
          timer_next_s = timer_r + 16'd1;
        end
      end
      ST_DONE: begin
        fv_next_s     = 1'b1;
        addr_next_s   = shift_r[23:0];
        data_next_s   = shift_r[39:24];
        osig_next_s   = shift_r[43:40];
        uvalid_next_s = shift_r[44];
        ubyte_next_s  = shift_r[55:48];
        timer_next_s  = 16'd0;
        state_next_s  = ST_GAP;
      end
      ST_GAP: begin
        if (timer_r == GAP_LAST) begin
          timer_next_s = 16'd0;
`ifdef AUTO_POLL_EN
          cmd_next_s   = {4'b0000, bus.INPUT_SIGNAL_IN};
          spiss_next_s = 1'b1;
          state_next_s = ST_SETUP;
`else
          busy_next_s  = 1'b0;
          state_next_s = ST_IDLE;
`endif
        end else begin
          timer_next_s = timer_r + 16'd1;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        timer_next_s  = 16'd0;
        edge_next_s   = 6'd0;
        spiclk_next_s = 1'b0;
        spisi_next_s  = 1'b0;
        spiss_next_s  = 1'b0;
        busy_next_s   = 1'b0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state_r  <= ST_IDLE;
      timer_r  <= 16'd0;
      edge_r   <= 6'd0;
      cmd_r    <= 8'd0;
      shift_r  <= 56'd0;
      spiclk_r <= 1'b0;
      spisi_r  <= 1'b0;
      spiss_r  <= 1'b0;
      busy_r   <= 1'b0;
      fv_r     <= 1'b0;
      addr_r   <= 24'd0;
      data_r   <= 16'd0;
      osig_r   <= 4'd0;
      uvalid_r <= 1'b0;
      ubyte_r  <= 8'd0;
    end else begin
      state_r  <= state_next_s;
      timer_r  <= timer_next_s;
      edge_r   <= edge_next_s;
      cmd_r    <= cmd_next_s;
      shift_r  <= shift_next_s;
      spiclk_r <= spiclk_next_s;
      spisi_r  <= spisi_next_s;
      spiss_r  <= spiss_next_s;
      busy_r   <= busy_next_s;
      fv_r     <= fv_next_s;
      addr_r   <= addr_next_s;
      data_r   <= data_next_s;
      osig_r   <= osig_next_s;
      uvalid_r <= uvalid_next_s;
      ubyte_r  <= ubyte_next_s;
    end
  end

  assign bus.SPICLK        = spiclk_r;
  assign bus.SPISI         = spisi_r;
  assign bus.SPISS         = spiss_r;
  assign bus.BUSY          = busy_r;
  assign bus.FRAME_VALID   = fv_r;
  assign bus.ADDR          = addr_r;
  assign bus.DATA          = data_r;
  assign bus.OUTPUT_SIGNAL = osig_r;
  assign bus.UART_VALID    = uvalid_r;
  assign bus.UART_BYTE     = ubyte_r;

endmodule

// File: tb/tb_monitor_spi_master.sv
// Directed bench for monitor_spi_master with a behavioural MODE1 monitor slave.
// Build with AUTO_POLL_EN defined to exercise the automatic polling variant.
module tb_monitor_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int SS_SETUP = 2;
  localparam int SS_GAP   = 8;
  localparam int LATENCY  = SS_SETUP + 112 * CLK_DIV + 1;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   cnt_a;
  int   cnt_b;
  int   cnt_c;

  logic [55:0] slave_frame;
  logic [55:0] slave_rx;
  int          slave_tx_idx;
  int          slave_rx_idx;

  monitor_spi_master_if bus ();

  monitor_spi_master #(
    .CLK_DIV (CLK_DIV),
    .SS_SETUP(SS_SETUP),
    .SS_GAP  (SS_GAP)
  ) dut (
    .MCLK_IN (clk),
    .RESET_IN(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: shifts frame out on SPICLK rise, captures MOSI on SPICLK fall, resets on select.
  task automatic slave_sel();
    forever begin
      @(posedge bus.SPISS);
      slave_tx_idx = 0;
      slave_rx_idx = 0;
    end
  endtask

  task automatic slave_tx();
    forever begin
      @(posedge bus.SPICLK);
      if (slave_tx_idx < 56) bus.SPISO_IN = slave_frame[slave_tx_idx];
      slave_tx_idx++;
    end
  endtask

  task automatic slave_rxp();
    forever begin
      @(negedge bus.SPICLK);
      if (slave_rx_idx < 56) slave_rx[slave_rx_idx] = bus.SPISI;
      slave_rx_idx++;
    end
  endtask

  task automatic start_frame(input logic [3:0] sig);
    @(negedge clk);
    bus.INPUT_SIGNAL_IN = sig;
    bus.START_IN = 1'b1;
    @(negedge clk);
    bus.START_IN = 1'b0;
  endtask

  task automatic wait_fv(input int start_cyc, output int c);
    c = start_cyc;
    while (c < 1000) begin
      @(negedge clk);
      c++;
      if (bus.FRAME_VALID === 1'b1) break;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_cmp = 0;
    n_err = 0;
    bus.START_IN = 1'b0;
    bus.INPUT_SIGNAL_IN = 4'h0;
    bus.SPISO_IN = 1'b0;
    slave_frame = 56'd0;
    slave_rx = 56'd0;
    slave_tx_idx = 0;
    slave_rx_idx = 0;
    fork
      slave_sel();
      slave_tx();
      slave_rxp();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_spiss", 64'(bus.SPISS), 64'd0);
    check("rst_spiclk", 64'(bus.SPICLK), 64'd0);
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_fv", 64'(bus.FRAME_VALID), 64'd0);
    check("rst_addr", 64'(bus.ADDR), 64'd0);

`ifdef AUTO_POLL_EN
    slave_frame = {8'h41, 4'b0001, 4'h5, 16'h1234, 24'hABCDEF};
    start_frame(4'b1010);
    wait_fv(0, cyc);
    check("auto_first_latency", 64'(cyc), 64'(LATENCY));
    cyc = 0;
    cnt_a = 0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.BUSY !== 1'b1) cnt_a++;
      if (bus.FRAME_VALID === 1'b1) break;
    end
    check("auto_period", 64'(cyc), 64'(SS_SETUP + 112 * CLK_DIV + SS_GAP + 1));
    check("auto_busy_low", 64'(cnt_a), 64'd0);
    check("auto_addr", 64'(bus.ADDR), 64'hABCDEF);
    check("auto_uart", 64'(bus.UART_BYTE), 64'h41);
`else
    // Frame 1: full field decode and command serialisation.
    slave_frame = {8'h41, 4'b0001, 4'h5, 16'h1234, 24'hABCDEF};
    start_frame(4'b1010);
    check("busy_after_start", 64'(bus.BUSY), 64'd1);
    check("spiss_after_start", 64'(bus.SPISS), 64'd1);
    wait_fv(0, cyc);
    check("f1_latency", 64'(cyc), 64'(LATENCY));
    check("f1_addr", 64'(bus.ADDR), 64'hABCDEF);
    check("f1_data", 64'(bus.DATA), 64'h1234);
    check("f1_osig", 64'(bus.OUTPUT_SIGNAL), 64'h5);
    check("f1_uvalid", 64'(bus.UART_VALID), 64'd1);
    check("f1_ubyte", 64'(bus.UART_BYTE), 64'h41);
    check("f1_spiss_done", 64'(bus.SPISS), 64'd0);
    check("f1_mosi_cmd", 64'(slave_rx[7:0]), 64'h0A);
    check("f1_mosi_zero", 64'(slave_rx[55:8]), 64'd0);
    check("f1_slave_insig", 64'(slave_rx[3:0]), 64'hA);
    @(negedge clk);
    check("f1_fv_one_cycle", 64'(bus.FRAME_VALID), 64'd0);
    while (bus.BUSY === 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end

    // Frame 2: empty flag nibble, previous values replaced only at DONE.
    slave_frame = {8'h00, 4'b0000, 4'hA, 16'h5678, 24'h123456};
    start_frame(4'b0101);
    repeat (100) @(negedge clk);
    check("f2_addr_held_midframe", 64'(bus.ADDR), 64'hABCDEF);
    wait_fv(100, cyc);
    check("f2_latency", 64'(cyc), 64'(LATENCY));
    check("f2_addr", 64'(bus.ADDR), 64'h123456);
    check("f2_data", 64'(bus.DATA), 64'h5678);
    check("f2_osig", 64'(bus.OUTPUT_SIGNAL), 64'hA);
    check("f2_uvalid", 64'(bus.UART_VALID), 64'd0);
    check("f2_ubyte", 64'(bus.UART_BYTE), 64'h00);
    check("f2_mosi_cmd", 64'(slave_rx[7:0]), 64'h05);
    repeat (SS_GAP + 2) @(negedge clk);

    // Reset asserted just after SPICLK rising edge 20.
    slave_frame = {8'h7E, 4'b0001, 4'h3, 16'hBEEF, 24'h00C0DE};
    start_frame(4'b0011);
    repeat (SS_SETUP + 40 * CLK_DIV) @(negedge clk);
    check("rise20_spiclk", 64'(bus.SPICLK), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_spiss", 64'(bus.SPISS), 64'd0);
    check("midrst_spiclk", 64'(bus.SPICLK), 64'd0);
    check("midrst_busy", 64'(bus.BUSY), 64'd0);
    check("midrst_addr", 64'(bus.ADDR), 64'd0);
    check("midrst_data", 64'(bus.DATA), 64'd0);
    check("midrst_uvalid", 64'(bus.UART_VALID), 64'd0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.FRAME_VALID === 1'b1) cnt_a++;
      if (bus.BUSY !== 1'b0) cnt_b++;
    end
    check("midrst_no_fv", 64'(cnt_a), 64'd0);
    check("midrst_stays_idle", 64'(cnt_b), 64'd0);
    start_frame(4'b0011);
    wait_fv(0, cyc);
    check("f3_latency", 64'(cyc), 64'(LATENCY));
    check("f3_addr", 64'(bus.ADDR), 64'h00C0DE);
    check("f3_data", 64'(bus.DATA), 64'hBEEF);
    check("f3_ubyte", 64'(bus.UART_BYTE), 64'h7E);
    repeat (SS_GAP + 2) @(negedge clk);

    // START pulses inside CLK_HI and GAP must be ignored.
    slave_frame = {8'h55, 4'b0001, 4'hC, 16'hA5A5, 24'h5A5A5A};
    start_frame(4'b1100);
    @(negedge clk);
    @(negedge clk);
    check("pulse_in_clk_hi", 64'(bus.SPICLK), 64'd1);
    bus.START_IN = 1'b1;
    @(negedge clk);
    bus.START_IN = 1'b0;
    wait_fv(3, cyc);
    check("f4_latency", 64'(cyc), 64'(LATENCY));
    check("f4_addr", 64'(bus.ADDR), 64'h5A5A5A);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.BUSY !== 1'b1) break;
      if (bus.SPISS !== 1'b0) cnt_b++;
      bus.START_IN = (i == 3) ? 1'b1 : 1'b0;
      cnt_a++;
      @(negedge clk);
    end
    bus.START_IN = 1'b0;
    check("gap_busy_cycles", 64'(cnt_a), 64'(SS_GAP));
    check("gap_spiss_low", 64'(cnt_b), 64'd0);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.FRAME_VALID === 1'b1) cnt_a++;
      if (bus.BUSY !== 1'b0) cnt_b++;
      if (bus.SPISS !== 1'b0) cnt_c++;
    end
    check("pulse_no_extra_fv", 64'(cnt_a), 64'd0);
    check("pulse_not_queued_busy", 64'(cnt_b), 64'd0);
    check("pulse_not_queued_ss", 64'(cnt_c), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
